// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: canonical NOP and the fetch queue entry.
package riscv_pkg;

    localparam int unsigned PKG_XLEN  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PKG_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry prefetch queue with push, pop, flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pops of an empty queue and pushes into a full, non-draining queue are dropped.
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && ((count != CW'(DEPTH)) || do_pop) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, halt and redirect around a prefetch queue.
// Optional FETCH_BYPASS_EN lets an empty queue forward imem_rdata straight to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     halt_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic            halted;
    entry_t          head;
    entry_t          push_data;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_pop_c;
    logic            bypass_c;
    logic            consume_c;
    logic            push_c;

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_c),
        .push_data (push_data),
        .pop       (fifo_pop_c),
        .head      (head),
        .count     (count)
    );

    // Handshake decode; redirect squashes any push this cycle.
    always_comb begin
        fifo_empty      = (count == '0);
        fifo_full       = (count == CW'(DEPTH));
        fifo_pop_c      = !fifo_empty && out_ready;
`ifdef FETCH_BYPASS_EN
        bypass_c        = fifo_empty && !halted && !redirect_valid;
`else
        bypass_c        = 1'b0;
`endif
        consume_c       = bypass_c && out_ready;
        push_c          = !halted && !redirect_valid && !consume_c &&
                          (!fifo_full || fifo_pop_c);
        push_data.instr = imem_rdata;
        push_data.pc    = fetch_pc;
    end

    // Decode-facing view: queue head, else (bypass) live fetch, else NOP at fetch_pc.
    always_comb begin
        out_valid = !fifo_empty;
        out_instr = head.instr;
        out_pc    = head.pc;
        if (fifo_empty) begin
            out_valid = bypass_c;
            out_pc    = fetch_pc;
`ifdef FETCH_BYPASS_EN
            out_instr = bypass_c ? imem_rdata : NOP_INSTR;
`else
            out_instr = NOP_INSTR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            halted   <= 1'b0;
        end else begin
            if (push_c || consume_c) fetch_pc <= fetch_pc + XLEN'(4);
            if (halt_req)            halted   <= 1'b1;
        end
    end

    assign imem_addr = fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): reset, streaming, backpressure,
// redirect, halt drain, mid-stream reset and PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0003;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, NOP);
        check("rst_pc",    out_pc,    32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);

        // Streaming with decode always ready: one entry per cycle, occupancy 1.
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("pre_first_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc",    out_pc,    32'(4 * k));
            check("stream_instr", out_instr, mem_word(32'(4 * k)));
            check("stream_count", 32'(count), 32'd1);
        end

        // Backpressure: queue saturates at 4, fetch stalls at 0x10.
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("bp_reset_count", 32'(count), 32'd0);
        for (int k = 0; k < 10; k++) tick();
        check("bp_count", 32'(count), 32'd4);
        check("bp_addr",  imem_addr, 32'h10);
        check("bp_pc",    out_pc,    32'h0);
        check("bp_valid", 32'(out_valid), 32'd1);

        // Redirect while full and popping: everything discarded, target aligned.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("redir_count", 32'(count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr",  imem_addr, 32'h100);
        check("redir_pc_empty", out_pc, 32'h100);
        check("redir_instr_empty", out_instr, NOP);
        tick();
        check("redir_tgt_valid", 32'(out_valid), 32'd1);
        check("redir_tgt_pc",    out_pc, 32'h100);
        check("redir_tgt_count", 32'(count), 32'd1);
        tick();
        check("redir_next_pc",   out_pc, 32'h104);

        // Halt: 0x0 and 0x4 drain, fetch frozen at 0x8 until redirect.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("halt_pc0", out_pc, 32'h0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_pc4",    out_pc,    32'h4);
        check("halt_addr8",  imem_addr, 32'h8);
        tick();
        check("halt_drained_valid", 32'(out_valid), 32'd0);
        check("halt_drained_count", 32'(count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halt_addr_hold", imem_addr, 32'h8);
            check("halt_count_hold", 32'(count), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("unhalt_valid", 32'(out_valid), 32'd1);
        check("unhalt_pc",    out_pc, 32'h200);

        // Reset mid-stream with three entries queued.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("mid_count3", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_instr", out_instr, NOP);
        check("mid_rst_addr",  imem_addr, 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // PC wraps modulo 2^32; pointers wrap through the full queue.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("wrap_count", 32'(count), 32'd4);
        check("wrap_addr",  imem_addr, 32'h8);
        check("wrap_head",  out_pc, 32'hFFFF_FFF8);
        out_ready = 1'b1;
        tick();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        check("wrap_cnt_steady", 32'(count), 32'd4);
        tick();
        check("wrap_pc2", out_pc, 32'h0);
        check("wrap_instr2", out_instr, mem_word(32'h0));
        tick();
        check("wrap_pc3", out_pc, 32'h4);
        tick();
        check("wrap_pc4", out_pc, 32'h8);
        check("wrap_instr4", out_instr, mem_word(32'h8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
